// File: rtl/jtcop_pkg.sv
// rtl/jtcop_pkg.sv - shared state encoding for the palette DMA
// Purpose: state type used by jtcop_paldma.
// Ports: none (package).
package jtcop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } paldma_state_e;

endpackage

// File: rtl/jtcop_paldma_arb.sv
// rtl/jtcop_paldma_arb.sv - combinational palette write-bus mux, DMA over CPU
// Purpose: selects which source drives the palette RAM write port this cycle.
// Ports:
//   dma_vld_i/dma_addr_i/dma_gr_i/dma_b_i   DMA write request and data
//   cpu_req_i/cpu_addr_i/cpu_gr_i/cpu_b_i/cpu_we_i  CPU write request (already
//                                            gated by the FSM) and data
//   addr_o/gr_o/b_o/we_gr_o/we_b_o           selected write bus, all zero when idle
//   cpu_ack_o                                 CPU write taken this cycle
module jtcop_paldma_arb #(
  parameter int AW    = 10,
  parameter int DW_GR = 16,
  parameter int DW_B  = 8
) (
  input  logic             dma_vld_i,
  input  logic [AW-1:0]    dma_addr_i,
  input  logic [DW_GR-1:0] dma_gr_i,
  input  logic [DW_B-1:0]  dma_b_i,
  input  logic             cpu_req_i,
  input  logic [AW-1:0]    cpu_addr_i,
  input  logic [DW_GR-1:0] cpu_gr_i,
  input  logic [DW_B-1:0]  cpu_b_i,
  input  logic [2:0]       cpu_we_i,
  output logic [AW-1:0]    addr_o,
  output logic [DW_GR-1:0] gr_o,
  output logic [DW_B-1:0]  b_o,
  output logic [1:0]       we_gr_o,
  output logic             we_b_o,
  output logic             cpu_ack_o
);

  always_comb begin
    addr_o    = '0;
    gr_o      = '0;
    b_o       = '0;
    we_gr_o   = 2'b00;
    we_b_o    = 1'b0;
    cpu_ack_o = 1'b0;
    if (dma_vld_i) begin
      addr_o  = dma_addr_i;
      gr_o    = dma_gr_i;
      b_o     = dma_b_i;
      we_gr_o = 2'b11;
      we_b_o  = 1'b1;
    end else if (cpu_req_i) begin
      addr_o    = cpu_addr_i;
      gr_o      = cpu_gr_i;
      b_o       = cpu_b_i;
      we_gr_o   = cpu_we_i[1:0];
      we_b_o    = cpu_we_i[2];
      cpu_ack_o = 1'b1;
    end
  end

endmodule

// File: rtl/jtcop_paldma.sv
// rtl/jtcop_paldma.sv - palette DMA: shadow RAM to palette RAM at vblank entry
// Purpose: armed by trig, copies 2**AW shadow entries into the palette RAMs,
//   one per clock, starting at the next vertical-blank entry. CPU palette
//   writes pass through when the DMA is not running and are stalled otherwise.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   LVBL                       vertical blank, active low
//   trig                       arm strobe
//   cpu_cs/cpu_addr/cpu_gr/cpu_b/cpu_we, cpu_ok   CPU write request / ack
//   src_addr, src_gr, src_b    shadow RAM read port (1 clk read latency)
//   pal_addr/pal_gr/pal_b/we_gr/we_b              palette RAM write port
//   busy, late                 transfer in progress / transfer overran vblank
module jtcop_paldma
  import jtcop_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DW_GR = 16,
  parameter int DW_B  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LVBL,
  input  logic             trig,
  input  logic             cpu_cs,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW_GR-1:0] cpu_gr,
  input  logic [DW_B-1:0]  cpu_b,
  input  logic [2:0]       cpu_we,
  output logic             cpu_ok,
  output logic [AW-1:0]    src_addr,
  input  logic [DW_GR-1:0] src_gr,
  input  logic [DW_B-1:0]  src_b,
  output logic [AW-1:0]    pal_addr,
  output logic [DW_GR-1:0] pal_gr,
  output logic [DW_B-1:0]  pal_b,
  output logic [1:0]       we_gr,
  output logic             we_b,
  output logic             busy,
  output logic             late
);

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  paldma_state_e    state_q, state_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             late_q, late_d;
  logic             busy_q, busy_d;
  logic             lvbl_q;
  // read issued last cycle: its data is on src_gr/src_b now
  logic             rd_vld_q;
  logic [AW-1:0]    rd_addr_q;

  logic             vb_fall, vb_rise, cpu_req;
  logic [AW-1:0]    wr_addr;
  logic [DW_GR-1:0] wr_gr;
  logic [DW_B-1:0]  wr_b;
  logic [1:0]       wr_we_gr;
  logic             wr_we_b, wr_ack;

  logic [AW-1:0]    pal_addr_q;
  logic [DW_GR-1:0] pal_gr_q;
  logic [DW_B-1:0]  pal_b_q;
  logic [1:0]       we_gr_q;
  logic             we_b_q, cpu_ok_q;

  assign vb_fall = lvbl_q & ~LVBL;
  assign vb_rise = ~lvbl_q & LVBL;
  assign cpu_req = cpu_cs & ((state_q == ST_IDLE) | (state_q == ST_WAIT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    late_d  = late_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig) begin
          late_d  = 1'b0;
          cnt_d   = '0;
          // an arm coinciding with vblank entry skips the wait
          state_d = vb_fall ? ST_RUN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (vb_fall) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && vb_rise) late_d = 1'b1;
    // FLUSH issues the last write; busy drops one clock after it lands
    busy_d = (state_d != ST_IDLE) || (state_q == ST_FLUSH);
  end

  jtcop_paldma_arb #(.AW(AW), .DW_GR(DW_GR), .DW_B(DW_B)) u_arb (
    .dma_vld_i  (rd_vld_q),
    .dma_addr_i (rd_addr_q),
    .dma_gr_i   (src_gr),
    .dma_b_i    (src_b),
    .cpu_req_i  (cpu_req),
    .cpu_addr_i (cpu_addr),
    .cpu_gr_i   (cpu_gr),
    .cpu_b_i    (cpu_b),
    .cpu_we_i   (cpu_we),
    .addr_o     (wr_addr),
    .gr_o       (wr_gr),
    .b_o        (wr_b),
    .we_gr_o    (wr_we_gr),
    .we_b_o     (wr_we_b),
    .cpu_ack_o  (wr_ack)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      late_q     <= 1'b0;
      busy_q     <= 1'b0;
      lvbl_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= '0;
      pal_addr_q <= '0;
      pal_gr_q   <= '0;
      pal_b_q    <= '0;
      we_gr_q    <= 2'b00;
      we_b_q     <= 1'b0;
      cpu_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      late_q     <= late_d;
      busy_q     <= busy_d;
      lvbl_q     <= LVBL;
      rd_vld_q   <= (state_q == ST_RUN);
      rd_addr_q  <= cnt_q[AW-1:0];
      pal_addr_q <= wr_addr;
      pal_gr_q   <= wr_gr;
      pal_b_q    <= wr_b;
      we_gr_q    <= wr_we_gr;
      we_b_q     <= wr_we_b;
      cpu_ok_q   <= wr_ack;
    end
  end

  assign src_addr = cnt_q[AW-1:0];
  assign pal_addr = pal_addr_q;
  assign pal_gr   = pal_gr_q;
  assign pal_b    = pal_b_q;
  assign we_gr    = we_gr_q;
  assign we_b     = we_b_q;
  assign cpu_ok   = cpu_ok_q;
  assign busy     = busy_q;
  assign late     = late_q;

endmodule

// File: tb/tb_jtcop_paldma.sv
// tb/tb_jtcop_paldma.sv - directed self-checking bench for jtcop_paldma
module tb_jtcop_paldma;

  localparam int AW = 10;
  localparam int N  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst, LVBL, trig, cpu_cs;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_gr;
  logic [7:0]  cpu_b;
  logic [2:0]  cpu_we;
  logic        cpu_ok;
  logic [9:0]  src_addr, pal_addr;
  logic [15:0] src_gr, pal_gr;
  logic [7:0]  src_b, pal_b;
  logic [1:0]  we_gr;
  logic        we_b, busy, late;

  logic [15:0] sh_gr [N];
  logic [7:0]  sh_b  [N];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  jtcop_paldma #(.AW(AW), .DW_GR(16), .DW_B(8)) dut (
    .clk(clk), .rst(rst), .LVBL(LVBL), .trig(trig),
    .cpu_cs(cpu_cs), .cpu_addr(cpu_addr), .cpu_gr(cpu_gr), .cpu_b(cpu_b),
    .cpu_we(cpu_we), .cpu_ok(cpu_ok),
    .src_addr(src_addr), .src_gr(src_gr), .src_b(src_b),
    .pal_addr(pal_addr), .pal_gr(pal_gr), .pal_b(pal_b),
    .we_gr(we_gr), .we_b(we_b), .busy(busy), .late(late)
  );

  // shadow RAM: synchronous read, one clock latency
  always @(posedge clk) begin
    src_gr <= sh_gr[src_addr];
    src_b  <= sh_b[src_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wv(input logic ok, input logic [1:0] wg, input logic wb,
                                     input logic [9:0] a, input logic [15:0] g, input logic [7:0] b);
    return {26'd0, ok, wg, wb, a, g, b};
  endfunction

  function automatic logic [63:0] obs_wr();
    return wv(cpu_ok, we_gr, we_b, pal_addr, pal_gr, pal_b);
  endfunction

  function automatic logic [63:0] dma_wr(input int n);
    logic [9:0] a;
    a = 10'(n);
    return wv(1'b0, 2'b11, 1'b1, a, sh_gr[n], sh_b[n]);
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      sh_gr[i] = 16'(i * 97 + 16'h0101);
      sh_b[i]  = 8'(i ^ 8'hC3);
    end
    sh_gr[N-1] = 16'hABCD;
    sh_b[N-1]  = 8'h5A;

    rst = 1'b1; LVBL = 1'b1; trig = 1'b0; cpu_cs = 1'b0;
    cpu_addr = '0; cpu_gr = '0; cpu_b = '0; cpu_we = '0;
    tick(); tick();
    chk("reset_outputs", {cpu_ok, we_gr, we_b, busy, late, src_addr, pal_addr, pal_gr, pal_b},
        64'd0);
    rst = 1'b0;
    tick();

    // arm and full transfer
    trig = 1'b1; tick(); trig = 1'b0;
    chk("arm_busy", {busy, we_gr, we_b}, {1'b1, 2'b00, 1'b0});
    tick(); tick();
    LVBL = 1'b0; tick();                         // vblank entry: RUN starts
    tick();
    chk("t1_first_latency", {we_gr, we_b}, 3'b000);
    for (int k = 2; k <= N + 1; k++) begin
      tick();
      chk("t1_write", obs_wr(), dma_wr(k - 2));
    end
    chk("t1_last_entry", {pal_addr, pal_gr, pal_b}, {10'h3FF, 16'hABCD, 8'h5A});
    chk("t1_busy_at_last", busy, 1);
    tick();
    chk("t1_done", {busy, late, we_gr, we_b}, 5'b00000);

    // CPU write while idle
    cpu_cs = 1'b1; cpu_addr = 10'h012; cpu_gr = 16'h1234; cpu_b = 8'h56; cpu_we = 3'b101;
    tick(); cpu_cs = 1'b0;
    chk("cpu_idle_write", obs_wr(), wv(1'b1, 2'b01, 1'b1, 10'h012, 16'h1234, 8'h56));
    tick();
    chk("cpu_ok_one_clk", {cpu_ok, we_gr, we_b}, 4'b0000);

    // CPU stall during transfer, trig while busy ignored
    LVBL = 1'b1; tick();
    trig = 1'b1; tick(); trig = 1'b0;
    chk("t3_busy", busy, 1);
    trig = 1'b1; tick(); trig = 1'b0;              // ignored in WAIT
    LVBL = 1'b0; tick();
    for (int k = 1; k <= N + 1; k++) begin
      if (k == 50) trig = 1'b1;
      if (k == 51) trig = 1'b0;
      tick();
      if (k >= 2) chk("t3_dma_write_stall", obs_wr(), dma_wr(k - 2));
      if (k == 100) begin
        cpu_cs = 1'b1; cpu_addr = 10'h2A5; cpu_gr = 16'hBEEF; cpu_b = 8'h3C; cpu_we = 3'b111;
      end
    end
    tick(); cpu_cs = 1'b0;
    chk("t3_cpu_after_flush", obs_wr(), wv(1'b1, 2'b11, 1'b1, 10'h2A5, 16'hBEEF, 8'h3C));
    chk("t3_busy_clear", {busy, late}, 2'b00);
    tick();
    chk("t3_cpu_ok_drop", {cpu_ok, we_gr, we_b}, 4'b0000);
    LVBL = 1'b1; tick(); LVBL = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_no_second_xfer", {busy, we_gr, we_b}, 4'b0000);
    end

    // trig coincident with vblank entry, then overrun
    LVBL = 1'b1; tick();
    trig = 1'b1; LVBL = 1'b0; tick(); trig = 1'b0;
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_run_next_clk", {src_addr, we_gr, we_b}, {10'd1, 3'b000});
    for (int k = 2; k <= N + 1; k++) begin
      tick();
      chk("t4_write", obs_wr(), dma_wr(k - 2));
      if (k == 501) begin
        chk("t4_late_before", late, 0);
        LVBL = 1'b1;
      end
      if (k == 502) chk("t4_late_set", late, 1);
    end
    tick();
    chk("t4_done_late_sticky", {busy, late}, 2'b01);
    tick();
    chk("t4_late_holds", late, 1);

    // new trig clears late; reset mid-run
    trig = 1'b1; tick(); trig = 1'b0;
    chk("t5_trig_clears_late", {busy, late}, 2'b10);
    LVBL = 1'b0; tick();
    for (int k = 1; k <= 300; k++) begin
      if (k == 200) LVBL = 1'b1;
      tick();
    end
    chk("t5_mid_state", {late, src_addr, obs_wr()}, {1'b1, 10'd300, dma_wr(298)});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_after_rst", {we_gr, we_b, busy, late, cpu_ok, src_addr}, 16'd0);
    LVBL = 1'b1; tick(); LVBL = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_no_writes", {busy, we_gr, we_b}, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtcop_paldma.md
Name: jtcop_paldma

Overview:
- Palette writer: copies a CPU-built palette shadow buffer into the red-green and blue palette RAMs, which the colour mixer reads during active video.
- A transfer is armed by a CPU strobe. It starts at the next vertical-blank entry and streams one entry per clock.
- Sits between the shadow RAM (read side) and the palette RAM write ports (gr/b), in parallel with direct CPU palette access. The DMA has priority over the CPU, and CPU writes are stalled while it runs.

Parameters:
AW, 10, palette address width; entry count is 2**AW
DW_GR, 16, width of the red-green word
DW_B, 8, width of the blue byte

Ports:
clk  in  1  system clock; the only clock
rst  in  1  synchronous, active-high reset
LVBL  in  1  vertical blank, active low
trig  in  1  CPU arm strobe, single-cycle pulse
cpu_cs  in  1  CPU direct palette write request, held until acknowledged
cpu_addr  in  AW  CPU palette address
cpu_gr  in  DW_GR  CPU red-green data
cpu_b  in  DW_B  CPU blue data
cpu_we  in  3  CPU byte enables: [1:0] gr bytes, [2] blue
cpu_ok  out  1  one-cycle acknowledge of a CPU write
src_addr  out  AW  shadow RAM read address
src_gr  in  DW_GR  shadow red-green data, valid 1 clk after src_addr
src_b  in  DW_B  shadow blue data, valid 1 clk after src_addr
pal_addr  out  AW  palette RAM write address
pal_gr  out  DW_GR  palette red-green write data
pal_b  out  DW_B  palette blue write data
we_gr  out  2  red-green byte write enables
we_b  out  1  blue write enable
busy  out  1  high from arm until the last DMA write
late  out  1  sticky: the transfer overran vertical blank

Behaviour:
- Reset values: every output is 0; state is IDLE; the armed flag is cleared.
- The vertical-blank entry event (vb_fall) is detected on a registered copy of LVBL: previous value 1, current value 0.
- States:
  - IDLE: trig moves to WAIT.
  - WAIT: on vb_fall, go to RUN with cnt=0. A vb_fall in the same cycle as trig counts, so the arm goes directly to RUN on the next clk.
  - RUN: drive src_addr=cnt and cnt++ each clk. After src_addr = 2**AW-1 is issued, go to FLUSH.
  - FLUSH: perform the final write, then return to IDLE.
- Pipeline:
  - The write for entry n happens 1 clk after its read: pal_addr=n, pal_gr=src_gr, pal_b=src_b, we_gr=2'b11, we_b=1.
  - A transfer takes 2**AW+1 clk from RUN entry to the last write.
  - cnt is AW+1 bits wide so it cannot wrap.
- busy: set the clk after trig; cleared the clk after the final write.
- trig while busy is ignored; there is no queueing.
- late: set if LVBL rises (blank ends) while in RUN or FLUSH. The transfer still completes. late clears only on the next trig accepted from IDLE, or on rst.
- CPU arbitration:
  - In IDLE or WAIT, a pending cpu_cs is written in the same clk: pal_* = cpu_*, we_gr=cpu_we[1:0], we_b=cpu_we[2], and cpu_ok pulses for 1 clk.
  - cpu_cs must drop after cpu_ok, or it is treated as a new request.
  - In RUN or FLUSH, cpu_ok stays 0 and the request waits.
  - If cpu_cs and vb_fall occur in the same clk while in WAIT, the CPU write is serviced in that clk and RUN starts the following clk.
- Outputs are registered. we_* are 0 on every clk with no write.
- rst mid-transfer: returns to IDLE at once and issues no further writes. Palette contents are left partially updated.

Decomposition:
- Shared package (jtcop_pkg): state encoding constants ST_IDLE, ST_WAIT, ST_RUN, ST_FLUSH.
- One natural sub-module: jtcop_paldma_arb, a purely combinational mux choosing between the CPU and DMA write buses. The FSM and counter stay in the top module.
- Instantiation alongside the colour mixer is done by the game top level.

Test Plan:
- Arm and transfer: rst, then trig with LVBL=1; after LVBL falls → busy=1, and 1024 writes on consecutive clks. pal_addr runs 0..1023, each carrying the shadow data for its address (check entry 0x3FF=0xABCD/0x5A). busy drops the clk after the last write; late=0.
- CPU write when idle: cpu_cs, cpu_addr=0x012, cpu_gr=0x1234, cpu_b=0x56, cpu_we=3'b101 → same-clk we_gr=2'b01, we_b=1, cpu_ok=1 for exactly 1 clk.
- CPU stall: cpu_cs at RUN cnt=100 → cpu_ok=0 until the final DMA write. The CPU write then lands 1 clk after FLUSH, with data unchanged.
- Overrun: LVBL rises after 500 writes → late=1; all 1024 writes still occur. A new trig clears late.
- Edge cases:
  - trig during busy → no second transfer.
  - trig in the same clk as vb_fall → RUN begins the next clk.
- Reset mid-run: rst at cnt=300 → the next clk has we_gr=0, we_b=0, busy=0, late=0. No writes occur until a new trig plus vb_fall.
